mem_boot_loader: RTL and testbench

//  Upstream stage of the CPU: owns the 16x8 program memory port. After reset it

---
 rtl/mem_boot_loader_if.sv | 33 +++
 rtl/mem_boot_loader.sv | 140 ++++++++++++++
 tb/tb_mem_boot_loader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_boot_loader_if.sv
// Bundle of the byte stream, CPU and program memory signals around the boot loader.
// slave is the loader's view; master is the surrounding system (stream source, CPU, memory).
interface mem_boot_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              start;
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rst;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              done;
    logic              err;

    modport slave (
        input  in_valid, in_data, start, cpu_read, cpu_write, cpu_address, cpu_wdata, mem_rdata,
        output in_ready, cpu_rdata, cpu_rst, mem_write, mem_address, mem_wdata, done, err
    );

    modport master (
        output in_valid, in_data, start, cpu_read, cpu_write, cpu_address, cpu_wdata, mem_rdata,
        input  in_ready, cpu_rdata, cpu_rst, mem_write, mem_address, mem_wdata, done, err
    );
endinterface

// File: rtl/mem_boot_loader.sv
// Boot loader: holds the CPU in reset while a byte stream fills program memory, then passes
// the CPU through to memory. Define MEM_BOOT_LOADER_CHECKSUM_EN to add a trailing checksum byte.
module mem_boot_loader #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int RELEASE_CYC = 2
) (
    input logic              clk,
    input logic              rst,
    mem_boot_loader_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int HOLD_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RELEASE_CYC - 1);

    typedef enum logic [2:0] {LOAD, HOLD, RUN, CHK, ERROR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              cpu_rst_q;
    logic              done_q;
    logic              ready;
    logic              hs;
    logic              unused_cpu_read;

`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    logic              err_q;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;

    assign ready    = (state == LOAD) || (state == CHK);
    assign sum_next = sum + bus.in_data;
    assign bus.err  = err_q;
`else
    assign ready    = (state == LOAD);
    assign bus.err  = 1'b0;
`endif

    assign hs              = bus.in_valid & ready;
    assign bus.in_ready    = ready;
    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.done        = done_q;
    assign unused_cpu_read = bus.cpu_read;

    // Sequencer: count stream bytes into memory, hold the CPU for a few cycles, then release it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            hold_cnt  <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
            err_q     <= 1'b0;
            sum       <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (hs) begin
                        cnt <= cnt + 1'b1;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
                        sum <= sum_next;
                        if (cnt == LAST_ADDR) state <= CHK;
`else
                        if (cnt == LAST_ADDR) state <= HOLD;
`endif
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt  <= '0;
                        state     <= RUN;
                        cpu_rst_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.start) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
                        sum       <= '0;
`endif
                    end
                end
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
                // The extra byte is only summed, never stored; a zero total releases the CPU.
                CHK: begin
                    if (hs) begin
                        if (sum_next == '0) begin
                            state <= HOLD;
                        end else begin
                            state <= ERROR;
                            err_q <= 1'b1;
                        end
                    end
                end
                ERROR: begin
                    if (bus.start) begin
                        state <= LOAD;
                        cnt   <= '0;
                        sum   <= '0;
                        err_q <= 1'b0;
                    end
                end
`endif
                default: state <= LOAD;
            endcase
        end
    end

    // Memory port mux: the loader owns memory until RUN, after which the CPU talks to it directly.
    always_comb begin
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.cpu_rdata   = '0;
        case (state)
            LOAD: begin
                bus.mem_write   = hs;
                bus.mem_address = cnt;
                bus.mem_wdata   = bus.in_data;
            end
            RUN: begin
                bus.mem_write   = bus.cpu_write;
                bus.mem_address = bus.cpu_address;
                bus.mem_wdata   = bus.cpu_wdata;
                bus.cpu_rdata   = bus.mem_rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_boot_loader.sv
// Self-checking bench for mem_boot_loader: vector table for the first boot, directed corner
// sequences, and randomized loads/CPU traffic checked against an expected-memory model.
module tb_mem_boot_loader;
    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 8;
    localparam int DEPTH       = 16;
    localparam int RELEASE_CYC = 2;

    typedef logic [7:0] img_t [DEPTH];

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       start;
        logic       cpu_write;
        logic [3:0] cpu_address;
        logic [7:0] cpu_wdata;
        logic       exp_in_ready;
        logic       exp_mem_write;
        logic [3:0] exp_mem_address;
        logic       exp_cpu_rst;
        logic       exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    vec_t       vecs[$];
    logic [7:0] mem     [DEPTH];
    logic [7:0] exp_mem [DEPTH];
    img_t       img;
    int         cyc;
    logic       w;
    logic [3:0] a;
    logic [7:0] d;

    always #5 clk = ~clk;

    mem_boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_boot_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RELEASE_CYC(RELEASE_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Program memory: synchronous write, combinational read.
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_address];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic vec_t mkv(input logic iv, input logic [7:0] id, input logic cw,
                                 input logic [3:0] ca, input logic er, input logic emw,
                                 input logic [3:0] ema, input logic ecr, input logic ed);
        vec_t v;
        v.in_valid = iv;  v.in_data = id;  v.start = 1'b0;
        v.cpu_write = cw; v.cpu_address = ca; v.cpu_wdata = 8'h5A;
        v.exp_in_ready = er; v.exp_mem_write = emw; v.exp_mem_address = ema;
        v.exp_cpu_rst = ecr; v.exp_done = ed;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input int idx);
        bus.in_valid    = v.in_valid;
        bus.in_data     = v.in_data;
        bus.start       = v.start;
        bus.cpu_write   = v.cpu_write;
        bus.cpu_address = v.cpu_address;
        bus.cpu_wdata   = v.cpu_wdata;
        #1;
        checkOutput($sformatf("vec%0d in_ready", idx), bus.in_ready, v.exp_in_ready);
        checkOutput($sformatf("vec%0d mem_write", idx), bus.mem_write, v.exp_mem_write);
        checkOutput($sformatf("vec%0d mem_address", idx), bus.mem_address, v.exp_mem_address);
        checkOutput($sformatf("vec%0d cpu_rst", idx), bus.cpu_rst, v.exp_cpu_rst);
        checkOutput($sformatf("vec%0d done", idx), bus.done, v.exp_done);
        tick();
    endtask

    task automatic checkMem(input string tag);
        for (int i = 0; i < DEPTH; i++)
            checkOutput($sformatf("%s mem[%0d]", tag, i), mem[i], exp_mem[i]);
    endtask

    task automatic pulseStart;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Feed one program image; mode 0 = always valid, 1 = valid on odd cycles, 2 = random.
    task automatic loadStream(input img_t bytes, input int mode, input bit send_chk, output int cycles);
        int   acc;
        logic v;
        acc    = 0;
        cycles = 0;
        while (acc < DEPTH && cycles < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = cycles[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? bytes[acc] : 8'($urandom);
            #1;
            checkOutput("load in_ready", bus.in_ready, 1);
            checkOutput("load mem_write", bus.mem_write, v);
            checkOutput("load mem_address", bus.mem_address, acc);
            checkOutput("load cpu_rst", bus.cpu_rst, 1);
            checkOutput("load cpu_rdata", bus.cpu_rdata, 0);
            tick();
            if (v) begin
                exp_mem[acc] = bytes[acc];
                acc++;
            end
            cycles++;
        end
        if (acc < DEPTH) checkOutput("load byte budget", acc, DEPTH);
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
        if (send_chk) begin
            logic [7:0] s;
            s = 8'h00;
            for (int i = 0; i < DEPTH; i++) s = s + bytes[i];
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h00 - s;
            #1;
            checkOutput("chk in_ready", bus.in_ready, 1);
            checkOutput("chk mem_write", bus.mem_write, 0);
            tick();
        end
`else
        if (send_chk) begin
            bus.in_valid = 1'b1;
            #1;
            checkOutput("no byte beyond depth", bus.in_ready, 0);
        end
`endif
        bus.in_valid = 1'b0;
    endtask

    task automatic waitRun(input string tag);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        while (bus.done !== 1'b1 && n < 20) begin
            #1;
            checkOutput({tag, " hold cpu_rst"}, bus.cpu_rst, 1);
            checkOutput({tag, " hold mem_write"}, bus.mem_write, 0);
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        checkOutput({tag, " hold cycles"}, n, RELEASE_CYC);
        checkOutput({tag, " run cpu_rst"}, bus.cpu_rst, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.start = 1'b0; bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0; bus.cpu_address = '0; bus.cpu_wdata = '0;
        tick();
        tick();
        #1;
        checkOutput("reset in_ready", bus.in_ready, 1);
        checkOutput("reset cpu_rst", bus.cpu_rst, 1);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset err", bus.err, 0);
        checkOutput("reset mem_address", bus.mem_address, 0);
        rst = 1'b0;

        // First boot: bytes 0x00..0x0F back to back, extra bytes offered in HOLD and RUN.
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back(mkv(1'b1, 8'(i), 1'b0, 4'd0, 1'b1, 1'b1, 4'(i), 1'b1, 1'b0));
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
        vecs.push_back(mkv(1'b1, 8'h88, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0));
`endif
        for (int i = 0; i < RELEASE_CYC; i++)
            vecs.push_back(mkv(1'b1, 8'h77, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
        vecs.push_back(mkv(1'b1, 8'h77, 1'b0, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1));
        foreach (vecs[i]) applyStimulus(vecs[i], i);
        bus.in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'(i);
        checkMem("t1");

        // CPU write then read-back through the RUN pass-through.
        bus.cpu_write = 1'b1; bus.cpu_address = 4'd5; bus.cpu_wdata = 8'hA5;
        #1;
        checkOutput("t3 mem_write", bus.mem_write, 1);
        checkOutput("t3 mem_address", bus.mem_address, 5);
        checkOutput("t3 mem_wdata", bus.mem_wdata, 8'hA5);
        tick();
        exp_mem[5] = 8'hA5;
        bus.cpu_write = 1'b0;
        #1;
        checkOutput("t3 cpu_rdata", bus.cpu_rdata, 8'hA5);

        // Reload from RUN; a CPU write during LOAD must not reach memory.
        pulseStart();
        #1;
        checkOutput("t5 cpu_rst", bus.cpu_rst, 1);
        checkOutput("t5 done", bus.done, 0);
        checkOutput("t5 in_ready", bus.in_ready, 1);
        bus.cpu_write = 1'b1; bus.cpu_address = 4'd7; bus.cpu_wdata = 8'h3C;
        #1;
        checkOutput("t3 load mem_write", bus.mem_write, 0);
        checkOutput("t3 load mem_address", bus.mem_address, 0);
        tick();
        bus.cpu_write = 1'b0;
        for (int i = 0; i < DEPTH; i++) img[i] = 8'hFF;
        loadStream(img, 0, 1'b1, cyc);
        waitRun("t5");
        checkMem("t5");

        // Valid toggling: only every other cycle carries a byte.
        pulseStart();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        loadStream(img, 1, 1'b1, cyc);
        checkOutput("t2 load cycles", cyc, 2 * DEPTH);
        waitRun("t2");
        checkMem("t2");

        // Reset mid-load restarts at address 0; start during LOAD is ignored.
        pulseStart();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hE0 + 8'(i);
            tick();
            exp_mem[i] = 8'hE0 + 8'(i);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        #1;
        checkOutput("t4 post-reset mem_address", bus.mem_address, 0);
        checkOutput("t4 post-reset cpu_rst", bus.cpu_rst, 1);
        pulseStart();
        #1;
        checkOutput("t4 start ignored in_ready", bus.in_ready, 1);
        checkOutput("t4 start ignored mem_address", bus.mem_address, 0);
        checkOutput("t4 start ignored done", bus.done, 0);
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h10 + 8'(i);
        loadStream(img, 0, 1'b1, cyc);
        waitRun("t4");
        checkMem("t4");

        // Random CPU traffic in RUN followed by randomly paced reloads.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 24; k++) begin
                w = 1'($urandom_range(0, 1));
                a = 4'($urandom_range(0, DEPTH - 1));
                d = 8'($urandom);
                bus.cpu_write = w; bus.cpu_address = a; bus.cpu_wdata = d;
                bus.cpu_read = 1'($urandom); bus.in_valid = 1'($urandom);
                #1;
                checkOutput("rand mem_write", bus.mem_write, w);
                checkOutput("rand mem_address", bus.mem_address, a);
                checkOutput("rand mem_wdata", bus.mem_wdata, d);
                checkOutput("rand cpu_rdata", bus.cpu_rdata, exp_mem[a]);
                checkOutput("rand in_ready", bus.in_ready, 0);
                tick();
                if (w) exp_mem[a] = d;
            end
            bus.cpu_write = 1'b0; bus.in_valid = 1'b0; bus.cpu_read = 1'b0;
            checkMem("rand run");
            pulseStart();
            for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
            loadStream(img, 2, 1'b1, cyc);
            waitRun("rand load");
            checkMem("rand load");
        end

`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
        // Good checksum releases the CPU; a bad one parks in ERROR until start.
        pulseStart();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h01;
        loadStream(img, 0, 1'b1, cyc);
        waitRun("t6 good");
        checkMem("t6 good");
        pulseStart();
        loadStream(img, 0, 1'b0, cyc);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hF1;
        #1;
        checkOutput("t6 bad mem_write", bus.mem_write, 0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checkOutput("t6 err", bus.err, 1);
        checkOutput("t6 err cpu_rst", bus.cpu_rst, 1);
        checkOutput("t6 err done", bus.done, 0);
        tick();
        checkOutput("t6 err sticky", bus.err, 1);
        pulseStart();
        #1;
        checkOutput("t6 err cleared", bus.err, 0);
        checkOutput("t6 reload in_ready", bus.in_ready, 1);
`else
        checkOutput("err tied low", bus.err, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
